// File: rtl/decoder_pkg.sv
// Shared encodings for the registered decoder: mode select values and FSM states.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_core.sv
// Combinational select decoder: one-hot (only bit `in`) or thermometer (bits `in`..0).
module decoder_core #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      in,
  input  logic                  therm,
  output logic [(1<<SEL_W)-1:0] out
);

  localparam int OUT_W = 1 << SEL_W;

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
    assign out[gi] = therm ? (SEL_W'(gi) <= in) : (SEL_W'(gi) == in);
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered decoder with direct one-hot/thermometer modes and a self-timed
// one-hot scan that dwells DWELL cycles per line and pulses wrap on rollover.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      in,
  output logic [(1<<SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap,
  output logic                  busy
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;

  logic               scan_hold;
  logic [SEL_W-1:0]   core_sel;
  logic               core_therm;
  logic [OUT_W-1:0]   core_out;

  // One decoder serves both the direct path (decode `in`) and the scan step (decode idx+1).
  assign scan_hold  = en && (mode == MODE_SCAN) && (state_q == SCAN);
  assign core_sel   = scan_hold ? (idx_q + SEL_W'(1)) : in;
  assign core_therm = (mode == MODE_THERM);

  decoder_core #(.SEL_W(SEL_W)) u_core (
    .in    (core_sel),
    .therm (core_therm),
    .out   (core_out)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = OFF;
      out_d   = '0;
      dwell_d = '0;
    end else if (mode == MODE_SCAN) begin
      state_d = SCAN;
      if (state_q != SCAN) begin
        idx_d   = in;
        dwell_d = '0;
        out_d   = core_out;
      end else if (dwell_q == DWELL_LAST) begin
        idx_d   = core_sel;
        dwell_d = '0;
        out_d   = core_out;
        wrap_d  = (idx_q == IDX_LAST);
      end else begin
        dwell_d = dwell_q + CNT_W'(1);
      end
    end else begin
      state_d = DIRECT;
      idx_d   = in;
      dwell_d = '0;
      out_d   = core_out;
    end
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      out_q   <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule
